// File: rtl/game_pkg.sv
// Shared types and defaults for the game mode controller.
// State encoding, default parameter values, small helpers.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_PLAY = 3'd2,
    S_OVER = 3'd3,
    S_WAIT = 3'd4
  } state_t;

  localparam int DEF_N_LEVELS      = 3;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_RESET_CYCLES  = 2;
  localparam int DEF_CNT_W         = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_mode_ctrl_if.sv
// Level request / game status bundle of the mode controller.
// master: switches + maze core side; slave: the controller.
interface game_mode_ctrl_if
  import game_pkg::*;
#(
  parameter int N_LEVELS = DEF_N_LEVELS,
  parameter int CNT_W    = DEF_CNT_W
);

  localparam int IW = $clog2(N_LEVELS);

  logic [N_LEVELS-1:0] level_req;
  logic                game_done;
  logic [N_LEVELS-1:0] play;
  logic [IW-1:0]       level_idx;
  logic                playing;
  logic                external_reset;
  logic [CNT_W-1:0]    games_played;

  modport master (
    output level_req,
    output game_done,
    input  play,
    input  level_idx,
    input  playing,
    input  external_reset,
    input  games_played
  );

  modport slave (
    input  level_req,
    input  game_done,
    output play,
    output level_idx,
    output playing,
    output external_reset,
    output games_played
  );

endinterface

// File: rtl/onehot_encode.sv
// One-hot check and binary encode of an N-bit vector.
// in_vec -> valid (exactly one bit set), idx (its position).
module onehot_encode #(
  parameter int N = 3
) (
  input  logic [N-1:0]         in_vec,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  // x & (x-1) clears the lowest set bit
  assign valid = (in_vec != '0) &&
                 ((in_vec & (in_vec - N'(1))) == '0);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (in_vec[i]) idx = idx | IW'(i);
    end
  end

endmodule

// File: rtl/game_mode_ctrl.sv
// Difficulty select / game lifecycle controller.
// clock, reset (sync, active-high), bus: game_mode_ctrl_if.slave.
module game_mode_ctrl
  import game_pkg::*;
#(
  parameter int N_LEVELS      = DEF_N_LEVELS,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic           clock,
  input  logic           reset,
  game_mode_ctrl_if.slave bus
);

  localparam int IW = $clog2(N_LEVELS);
  localparam int CW =
    $clog2(max2(STABLE_CYCLES, RESET_CYCLES)) + 1;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_LEVELS-1:0] cap_q, cap_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]    games_q, games_d;

  logic                oh_valid;
  logic [IW-1:0]       oh_idx;

  onehot_encode #(
    .N(N_LEVELS)
  ) u_enc (
    .in_vec (bus.level_req),
    .valid  (oh_valid),
    .idx    (oh_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      idx_q   <= '0;
      games_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      idx_q   <= idx_d;
      games_q <= games_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    idx_d   = idx_q;
    games_d = games_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (oh_valid) begin
          cap_d   = bus.level_req;
          idx_d   = oh_idx;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (bus.level_req != cap_q) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_PLAY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PLAY: begin
        // only the captured switch matters while playing
        if (bus.game_done || ((bus.level_req & cap_q) == '0)) begin
          cnt_d   = '0;
          state_d = S_OVER;
          if (games_q != '1) games_d = games_q + 1'b1;
        end
      end
      S_OVER: begin
        if (cnt_q == CW'(RESET_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.level_req == '0) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.playing        = (state_q == S_PLAY);
  assign bus.external_reset = (state_q == S_OVER);
  assign bus.play           = (state_q == S_PLAY) ? cap_q : '0;
  assign bus.level_idx      =
    ((state_q == S_ARM) || (state_q == S_PLAY)) ? idx_q : '0;
  assign bus.games_played   = games_q;

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Directed bench for game_mode_ctrl (3 levels, 4/2 cycles, 8-bit count).
// Vector table plus hand sequences for multi-cycle corners.
module tb_game_mode_ctrl;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  game_mode_ctrl_if #(.N_LEVELS(3), .CNT_W(8)) bus ();

  game_mode_ctrl #(
    .N_LEVELS      (3),
    .STABLE_CYCLES (4),
    .RESET_CYCLES  (2),
    .CNT_W         (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] req;
    logic       done;
    logic [2:0] play;
    logic [1:0] idx;
    logic       playing;
    logic       ext;
    logic [7:0] games;
  } vec_t;

  vec_t tbl[17];

  task automatic cmp(input string nm, input string f,
                     input logic [7:0] got,
                     input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s got %0h want %0h", nm, f, got, want);
    end
  endtask

  task automatic chk(input string nm,
                     input logic [2:0] ep,
                     input logic [1:0] ei,
                     input logic epl,
                     input logic eer,
                     input logic [7:0] eg);
    cmp(nm, "play", {5'd0, bus.play}, {5'd0, ep});
    cmp(nm, "level_idx", {6'd0, bus.level_idx}, {6'd0, ei});
    cmp(nm, "playing", {7'd0, bus.playing}, {7'd0, epl});
    cmp(nm, "external_reset",
        {7'd0, bus.external_reset}, {7'd0, eer});
    cmp(nm, "games_played", bus.games_played, eg);
  endtask

  task automatic step(input logic [2:0] r,
                      input logic d,
                      input logic rs);
    bus.level_req = r;
    bus.game_done = d;
    reset         = rs;
    @(posedge clock);
    #1;
  endtask

  logic [7:0] eg;
  int         n;

  initial begin
    checks = 0;
    errors = 0;
    // req done | play idx playing ext games
    tbl[0]  = '{3'b010, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{3'b010, 1'b0, 3'b000, 2'd1, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{3'b010, 1'b1, 3'b000, 2'd1, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{3'b010, 1'b0, 3'b000, 2'd1, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{3'b010, 1'b0, 3'b000, 2'd1, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{3'b010, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0, 8'd0};
    tbl[6]  = '{3'b010, 1'b1, 3'b010, 2'd1, 1'b1, 1'b0, 8'd0};
    tbl[7]  = '{3'b010, 1'b0, 3'b000, 2'd0, 1'b0, 1'b1, 8'd1};
    tbl[8]  = '{3'b010, 1'b0, 3'b000, 2'd0, 1'b0, 1'b1, 8'd1};
    tbl[9]  = '{3'b010, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0, 8'd1};
    tbl[10] = '{3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 8'd1};
    tbl[11] = '{3'b100, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 8'd1};
    tbl[12] = '{3'b100, 1'b0, 3'b000, 2'd2, 1'b0, 1'b0, 8'd1};
    tbl[13] = '{3'b100, 1'b0, 3'b000, 2'd2, 1'b0, 1'b0, 8'd1};
    tbl[14] = '{3'b000, 1'b0, 3'b000, 2'd2, 1'b0, 1'b0, 8'd1};
    tbl[15] = '{3'b000, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0, 8'd1};
    tbl[16] = '{3'b000, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 8'd1};

    bus.level_req = 3'b000;
    bus.game_done = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset", 3'b000, 2'd0, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      bus.level_req = tbl[i].req;
      bus.game_done = tbl[i].done;
      chk($sformatf("vec%0d", i), tbl[i].play, tbl[i].idx,
          tbl[i].playing, tbl[i].ext, tbl[i].games);
      @(posedge clock);
      #1;
    end
    eg = 8'd1;

    for (int i = 0; i < 10; i++) begin
      step(3'b011, 1'b0, 1'b0);
      chk("multi_hot", 3'b000, 2'd0, 1'b0, 1'b0, eg);
    end
    step(3'b000, 1'b0, 1'b0);

    repeat (5) step(3'b001, 1'b0, 1'b0);
    chk("lvl0_play", 3'b001, 2'd0, 1'b1, 1'b0, eg);
    step(3'b001, 1'b1, 1'b0);
    eg = eg + 8'd1;
    chk("lvl0_over", 3'b000, 2'd0, 1'b0, 1'b1, eg);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.external_reset) n++;
      step(3'b001, 1'b0, 1'b0);
    end
    cmp("lvl0_pulse", "width", 8'(n), 8'd2);
    chk("lvl0_wait", 3'b000, 2'd0, 1'b0, 1'b0, eg);
    step(3'b000, 1'b0, 1'b0);
    repeat (5) step(3'b001, 1'b0, 1'b0);
    chk("relaunch", 3'b001, 2'd0, 1'b1, 1'b0, eg);
    step(3'b000, 1'b0, 1'b0);
    eg = eg + 8'd1;
    chk("drop_over", 3'b000, 2'd0, 1'b0, 1'b1, eg);
    repeat (3) step(3'b000, 1'b0, 1'b0);

    repeat (5) step(3'b100, 1'b0, 1'b0);
    chk("lvl2_play", 3'b100, 2'd2, 1'b1, 1'b0, eg);
    step(3'b101, 1'b0, 1'b0);
    chk("lvl2_b0_set", 3'b100, 2'd2, 1'b1, 1'b0, eg);
    step(3'b100, 1'b0, 1'b0);
    chk("lvl2_b0_clr", 3'b100, 2'd2, 1'b1, 1'b0, eg);
    step(3'b001, 1'b0, 1'b0);
    eg = eg + 8'd1;
    chk("lvl2_drop", 3'b000, 2'd0, 1'b0, 1'b1, eg);
    repeat (3) step(3'b000, 1'b0, 1'b0);

    for (int g = 0; g < 252; g++) begin
      repeat (5) step(3'b001, 1'b0, 1'b0);
      step(3'b001, 1'b1, 1'b0);
      if (eg != 8'd255) eg = eg + 8'd1;
      repeat (3) step(3'b000, 1'b0, 1'b0);
      cmp("sat_loop", "games_played", bus.games_played, eg);
    end
    cmp("saturate", "games_played", bus.games_played, 8'd255);

    repeat (5) step(3'b001, 1'b0, 1'b0);
    chk("pre_rst_play", 3'b001, 2'd0, 1'b1, 1'b0, 8'd255);
    step(3'b001, 1'b0, 1'b1);
    chk("rst_play", 3'b000, 2'd0, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 4; k++) begin
      step(3'b001, 1'b0, 1'b0);
      cmp("post_rst", "external_reset",
          {7'd0, bus.external_reset}, 8'd0);
    end
    step(3'b001, 1'b0, 1'b0);
    chk("replay", 3'b001, 2'd0, 1'b1, 1'b0, 8'd0);
    step(3'b001, 1'b1, 1'b0);
    chk("pre_rst_over", 3'b000, 2'd0, 1'b0, 1'b1, 8'd1);
    step(3'b001, 1'b0, 1'b1);
    chk("rst_over", 3'b000, 2'd0, 1'b0, 1'b0, 8'd0);
    step(3'b001, 1'b0, 1'b0);
    cmp("post_rst2", "external_reset",
        {7'd0, bus.external_reset}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
